// File: rtl/vga_pkg.sv
// Display timing constants and shared types for the VGA timing monitor.
// Optional checksum logic elsewhere is enabled by VGA_MON_CHECKSUM_EN.
package vga_pkg;

  localparam int HOR_TOTAL_TIME = 1344;
  localparam int HOR_SYNC_TIME  = 136;
  localparam int VER_TOTAL_TIME = 806;
  localparam int VER_SYNC_TIME  = 6;

  localparam int ERR_HT = 0;
  localparam int ERR_HS = 1;
  localparam int ERR_VT = 2;
  localparam int ERR_VS = 3;

  localparam int RGB_W  = 12;
  localparam int CSUM_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } mon_state_t;

  // A saturated counter can never be trusted as a real measurement.
  function automatic logic mism(
    input logic [31:0] val,
    input logic [31:0] exp_v,
    input logic [31:0] maxv
  );
    return (val != exp_v) || (val == maxv);
  endfunction

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Video tap bundle: sync and colour exactly as they leave the pipeline.
// The pipeline side drives it, the monitor only listens.
interface vga_timing_monitor_if;

  logic       vs;
  logic       hs;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;

  modport master (
    output vs, hs, r, g, b
  );

  modport slave (
    input vs, hs, r, g, b
  );

endinterface

// File: rtl/sync_meter.sv
// Edge detect, period and active-width counters for one sync signal,
// counted in units of a tick enable; both counters saturate.
module sync_meter #(
  parameter logic ACTIVE = 1'b0,
  parameter int   CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_i,
  input  logic          tick_i,
  output logic          lead_o,
  output logic [CW-1:0] per_o,
  output logic [CW-1:0] wid_o,
  output logic          per_sat_o,
  output logic          wid_sat_o
);

  localparam logic [CW-1:0] MAXV = '1;
  localparam logic [CW-1:0] ONE  = 1;

  logic          prev_q;
  logic          act;
  logic [CW-1:0] per_cnt_q;
  logic [CW-1:0] per_cnt_d;
  logic [CW-1:0] wid_cnt_q;
  logic [CW-1:0] wid_cnt_d;
  logic [CW-1:0] per_q;
  logic [CW-1:0] wid_q;
  logic [CW-1:0] seed;

  assign act       = (s_i == ACTIVE);
  assign lead_o    = act && (prev_q != ACTIVE);
  assign per_sat_o = (per_cnt_q == MAXV);
  assign wid_sat_o = (wid_cnt_q == MAXV);
  assign seed      = tick_i ? ONE : '0;

  // Expose the value being captured this cycle so it is usable at the edge.
  assign per_o = lead_o ? per_cnt_q : per_q;
  assign wid_o = lead_o ? wid_cnt_q : wid_q;

  always_comb begin
    per_cnt_d = per_cnt_q;
    wid_cnt_d = wid_cnt_q;
    if (lead_o) begin
      per_cnt_d = seed;
      wid_cnt_d = seed;
    end else if (tick_i) begin
      if (!per_sat_o)
        per_cnt_d = per_cnt_q + ONE;
      if (act && !wid_sat_o)
        wid_cnt_d = wid_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= ~ACTIVE;
      per_cnt_q <= '0;
      wid_cnt_q <= '0;
      per_q     <= '0;
      wid_q     <= '0;
    end else begin
      prev_q    <= s_i;
      per_cnt_q <= per_cnt_d;
      wid_cnt_q <= wid_cnt_d;
      if (lead_o) begin
        per_q <= per_cnt_q;
        wid_q <= wid_cnt_q;
      end
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// Line/frame timing monitor with lock status and sticky error flags.
// Define VGA_MON_CHECKSUM_EN to add the per-frame pixel checksum.
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter logic HS_ACTIVE   = 1'b0,
  parameter logic VS_ACTIVE   = 1'b0,
  parameter int   CW          = 11,
  parameter int   EXP_H_TOTAL = HOR_TOTAL_TIME,
  parameter int   EXP_H_SYNC  = HOR_SYNC_TIME,
  parameter int   EXP_V_TOTAL = VER_TOTAL_TIME,
  parameter int   EXP_V_SYNC  = VER_SYNC_TIME
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_timing_monitor_if.slave  vid,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 frame_done,
  output logic [CW-1:0]        h_total,
  output logic [CW-1:0]        h_sync,
  output logic [CW-1:0]        v_total,
  output logic [CW-1:0]        v_sync,
  output logic [3:0]           err_flags,
  output logic [15:0]          frame_cnt,
  output logic [CSUM_W-1:0]    checksum
);

  localparam logic [CW-1:0] MAXV = '1;
  localparam logic [31:0]   MAX32 = 32'(MAXV);

  logic          vs_q;
  logic          hs_q;

  logic          h_lead;
  logic [CW-1:0] h_per;
  logic [CW-1:0] h_wid;
  logic          h_psat;
  logic          h_wsat;
  logic          v_lead;
  logic [CW-1:0] v_per;
  logic [CW-1:0] v_wid;
  logic          v_psat;
  logic          v_wsat;

  mon_state_t    state_q;
  logic [3:0]    pend_q;
  logic [3:0]    pend_d;
  logic [3:0]    res_d;
  logic [3:0]    line_mm;
  logic [3:0]    frame_mm;
  logic [3:0]    sat_mm;
  logic [3:0]    err_q;
  logic [3:0]    err_d;
  logic          frame_end;

  logic          locked_q;
  logic          done_q;
  logic [CW-1:0] h_total_q;
  logic [CW-1:0] h_sync_q;
  logic [CW-1:0] v_total_q;
  logic [CW-1:0] v_sync_q;
  logic [15:0]   frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= ~VS_ACTIVE;
      hs_q <= ~HS_ACTIVE;
    end else begin
      vs_q <= vid.vs;
      hs_q <= vid.hs;
    end
  end

  sync_meter #(
    .ACTIVE (HS_ACTIVE),
    .CW     (CW)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .s_i       (hs_q),
    .tick_i    (1'b1),
    .lead_o    (h_lead),
    .per_o     (h_per),
    .wid_o     (h_wid),
    .per_sat_o (h_psat),
    .wid_sat_o (h_wsat)
  );

  // Vertical counts are in lines: one tick per hs leading edge.
  sync_meter #(
    .ACTIVE (VS_ACTIVE),
    .CW     (CW)
  ) u_vs (
    .clk       (clk),
    .rst       (rst),
    .s_i       (vs_q),
    .tick_i    (h_lead),
    .lead_o    (v_lead),
    .per_o     (v_per),
    .wid_o     (v_wid),
    .per_sat_o (v_psat),
    .wid_sat_o (v_wsat)
  );

  always_comb begin
    line_mm = '0;
    if (h_lead) begin
      line_mm[ERR_HT] = mism(32'(h_per), 32'(EXP_H_TOTAL), MAX32);
      line_mm[ERR_HS] = mism(32'(h_wid), 32'(EXP_H_SYNC), MAX32);
    end
    frame_mm         = '0;
    frame_mm[ERR_VT] = mism(32'(v_per), 32'(EXP_V_TOTAL), MAX32);
    frame_mm[ERR_VS] = mism(32'(v_wid), 32'(EXP_V_SYNC), MAX32);
    sat_mm    = {v_wsat, v_psat, h_wsat, h_psat};
    pend_d    = pend_q | line_mm | sat_mm;
    res_d     = pend_d | frame_mm;
    frame_end = v_lead && (state_q != IDLE);
    err_d     = err_clr ? 4'h0 : err_q;
    if (frame_end)
      err_d = err_d | res_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      err_q       <= '0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      h_total_q   <= '0;
      h_sync_q    <= '0;
      v_total_q   <= '0;
      v_sync_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      unique case (state_q)
        IDLE: begin
          pend_q <= '0;
          if (v_lead)
            state_q <= ACQUIRE;
        end
        ACQUIRE, LOCKED: begin
          if (v_lead) begin
            done_q      <= 1'b1;
            h_total_q   <= h_per;
            h_sync_q    <= h_wid;
            v_total_q   <= v_per;
            v_sync_q    <= v_wid;
            pend_q      <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            locked_q    <= (res_d == 4'h0);
            state_q     <= (res_d == 4'h0) ? LOCKED : ACQUIRE;
          end else begin
            pend_q <= pend_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [RGB_W-1:0]  rgb_q;
  logic [CSUM_W-1:0] acc_q;
  logic [CSUM_W-1:0] acc_d;
  logic [CSUM_W-1:0] pix;
  logic [CSUM_W-1:0] csum_q;

  assign pix   = {{(CSUM_W-RGB_W){1'b0}}, rgb_q};
  assign acc_d = v_lead ? pix : acc_q + pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q  <= '0;
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      rgb_q <= {vid.r, vid.g, vid.b};
      acc_q <= acc_d;
      if (frame_end)
        csum_q <= acc_q;
    end
  end

  assign checksum = csum_q;
`else
  logic unused_rgb;

  assign unused_rgb = ^{vid.r, vid.g, vid.b};
  assign checksum   = '0;
`endif

  assign locked     = locked_q;
  assign frame_done = done_q;
  assign h_total    = h_total_q;
  assign h_sync     = h_sync_q;
  assign v_total    = v_total_q;
  assign v_sync     = v_sync_q;
  assign err_flags  = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Synthesizable monitor downstream of top_vga's output stage; taps vs, hs and r/g/b exactly as they leave the display pipeline.
- Measures line and frame timing, checks it against the 1024x768@60 constants and reports lock status.
- Keeps a per-frame pixel checksum, which gives self-checking benches a frame signature alongside the TIFF dump.
- Also usable in hardware as a debug probe.

Parameters:
- HS_ACTIVE, 1'b0: hs active level (0 = active-low)
- VS_ACTIVE, 1'b0: vs active level
- CW, 11: width of all measurement counters and outputs

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- vs  in  1  vertical sync from display pipeline
- hs  in  1  horizontal sync from display pipeline
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- err_clr  in  1  one-cycle pulse; clears err_flags
- locked  out  1  timing matches constants
- frame_done  out  1  one-cycle pulse when frame results update
- h_total  out  CW  clocks between the last two hs leading edges
- h_sync  out  CW  last hs active width, in clocks
- v_total  out  CW  hs leading edges in the last frame
- v_sync  out  CW  hs leading edges while vs was active
- err_flags  out  4  sticky; [0] h_total, [1] h_sync, [2] v_total, [3] v_sync mismatch
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
- checksum  out  24  last frame pixel sum

Behaviour:
- Inputs registered once; leading edge = previous sample inactive, current sample active.
- Reset: all outputs 0, FSM in IDLE.
- FSM IDLE -> ACQUIRE on first vs leading edge. In this transition: counters start, no frame_done.
- ACQUIRE -> LOCKED when a frame ends with no mismatch.
- LOCKED -> ACQUIRE when a frame ends with any mismatch.
- ACQUIRE stays in ACQUIRE on mismatch.
- Line check at each hs leading edge:
  - captured period vs HOR_TOTAL_TIME (1344).
  - captured width vs HOR_SYNC_TIME (136).
  - Any mismatch sets that frame's pending bit.
- hs counter: reloads to 1 on hs leading edge, else increments.
- Line counter: at vs leading edge, captures lines counted so far and reloads to (hs leading edge ? 1 : 0). Coincident edges therefore count the line in the new frame.
- Frame check at each vs leading edge (not in IDLE):
  - v_total vs VER_TOTAL_TIME (806).
  - v_sync vs VER_SYNC_TIME (6).
- All counters saturate at 2^CW-1. A saturated value always mismatches.
- vs edge cycle+1 (frame end):
  - frame_done=1.
  - Outputs update.
  - err_flags |= pending bits; pending cleared.
  - frame_cnt++.
  - locked = (no pending bits).
- err_clr clears err_flags the same cycle. If it coincides with a frame end, newly set bits win.
- No hs for 2^CW clocks: h counter saturates, mismatch pending; locked unaffected until next frame end.
- rst mid-frame: FSM to IDLE, all outputs/counters 0; next vs edge starts a fresh acquisition.
- Latency: input pin to frame_done = 2 clocks after the vs transition.

Optional Feature:
- Macro VGA_MON_CHECKSUM_EN.
- Defined: 24-bit accumulator adds {r,g,b} as a 12-bit unsigned value every clock, modulo 2^24.
  - Captured into checksum at frame end.
  - Cleared to the current-cycle pixel value at vs leading edge.
- Undefined: no accumulator; checksum tied to 0.

Decomposition:
- vga_pkg holds HOR_TOTAL_TIME, HOR_SYNC_TIME, VER_TOTAL_TIME, VER_SYNC_TIME; add VER_SYNC_TIME if absent.
- Monitor-local typedef for FSM state (IDLE, ACQUIRE, LOCKED) goes in vga_pkg as mon_state_t.
- Sub-module sync_meter, instantiated twice:
  - Function: edge detect, period counter and active-width counter of one sync signal, counted in units of a tick enable.
  - hs instance: tick=1.
  - vs instance: tick = hs leading edge.

Test Plan:
- Nominal: 3 frames of 1344x806 timing, hs low 136 clocks, vs low 6 lines.
  - frame_done twice, locked=1 after the 2nd.
  - h_total=1344, h_sync=136, v_total=806, v_sync=6.
  - err_flags=0, frame_cnt=2.
- One line of 1343 clocks in frame 2:
  - err_flags=4'b0001, locked=0 at that frame end.
  - Next clean frame: locked=1, err_flags stays 1.
  - err_clr pulse -> err_flags=0.
- vs held low 7 lines: err_flags[3]=1, v_sync=7, locked=0.
- hs stuck inactive 3000 clocks: h_total=2047, err_flags[0]=1 at next frame end.
- rst asserted mid-frame 2:
  - All outputs 0 next cycle.
  - First vs edge after release gives no frame_done; second gives frame_cnt=1.
- VGA_MON_CHECKSUM_EN: r=g=b=4'hF for 100 clocks per frame, else 0 -> checksum=24'h063F9C; macro off -> checksum=0.
